// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- data-memory controller for an RV32I M-stage.
//
// A request is held in the pipeline (stall=1) while the word array is
// accessed for LATENCY cycles. The result is then reported for exactly one
// cycle (rvalid=1). Loads return byte/half/word data, sign- or zero-extended
// according to funct3. Stores write the selected byte lanes; their
// completion returns rdata=0.
//
// Optional feature: define DMEM_MISALIGN_CHECK_EN to detect misaligned
// H/HU/W accesses. A misaligned access writes nothing, returns 0 and raises
// misalign alongside rvalid. Without the macro, misalign is tied low and the
// low address bits that do not fit the access width are ignored.
//
// Parameters
//   DEPTH_WORDS  array size in 32-bit words (power of two)
//   LATENCY      array access cycles, 1..15
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-high reset (array contents are kept)
//   req_valid    memory operation present in M stage
//   req_we       1 = store, 0 = load
//   req_funct3   000 B, 001 H, 010 W, 100 BU, 101 HU (011/110/111 act as W)
//   req_addr     byte address; bits above the array index wrap
//   req_wdata    LSB-aligned store data
//   rdata        registered, extended load data (0 for stores)
//   rvalid       one-cycle completion strobe
//   stall        hold request to hazard unit
//   misalign     misaligned-access flag, valid with rvalid
//
// Handshake: stall is the inverse of ready. A request is taken in the cycle
// where req_valid=1 and the controller is IDLE. stall stays high from that
// cycle until the access ends. The completion cycle (rvalid=1) never accepts
// a new request.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        stall,
    output logic        misalign
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept;
    logic        finish;   // last ACCESS cycle: the next edge commits/reads

    // Captured request
    logic          we_q;
    logic [2:0]    f3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    // Address bits above the array index are ignored (modulo wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW+2];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        finish     = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    stall      = 1'b1;
                    accept     = 1'b1;
                    state_next = ACCESS;
                    cnt_next   = CNT_INIT;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (cnt == 4'd0) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rvalid = (state == DONE);

    // ---------------- request capture ----------------
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
        end
    end

    // ---------------- width decode ----------------
    logic          is_b, is_h, is_w, is_unsigned, mis;
    logic [1:0]    lane;
    logic [AW-1:0] idx;

    assign is_b        = (f3_q[1:0] == 2'b00);
    assign is_h        = (f3_q[1:0] == 2'b01);
    assign is_w        = !is_b && !is_h;   // 010, 011, 110, 111
    assign is_unsigned = f3_q[2];
    assign lane        = addr_q[1:0];
    assign idx         = addr_q[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    logic mis_q;
    assign mis = (is_h && addr_q[0]) || (is_w && (addr_q[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (reset)       mis_q <= 1'b0;
        else if (finish) mis_q <= mis;
    end

    assign misalign = (state == DONE) && mis_q;
`else
    assign mis      = 1'b0;
    assign misalign = 1'b0;
`endif

    // ---------------- store path ----------------
    logic [3:0]  be;
    logic [31:0] wword;

    always_comb begin
        be    = 4'b1111;
        wword = wdata_q;
        if (is_b) begin
            be    = 4'b0001 << lane;
            wword = {4{wdata_q[7:0]}};
        end else if (is_h) begin
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata_q[15:0]}};
        end
    end

    // No reset on the array: contents survive reset. The write happens on
    // the edge entering DONE, so a reset during ACCESS drops it.
    always_ff @(posedge clk) begin
        if (!reset && finish && we_q && !mis) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    // ---------------- load path ----------------
    logic [31:0] word, load_ext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign word     = mem[idx];
    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = addr_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_ext = word;
        if (is_b)
            load_ext = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        else if (is_h)
            load_ext = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end

    // rdata only changes on the edge into DONE (or reset), so it holds the
    // last result until the next completion.
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= 32'd0;
        else if (finish)
            rdata <= (we_q || mis) ? 32'd0 : load_ext;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (LATENCY=2, DEPTH_WORDS=1024).
// A byte-addressed reference memory plus cycle windows predicts stall,
// rvalid, misalign and rdata every cycle. Directed requests also carry
// hand-computed rdata/latency expectations.
module tb_dmem_ctrl;
    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
    logic        misalign;

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .stall      (stall),
        .misalign   (misalign)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [0:4*DEPTH-1];
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          busy = 1'b0;
    bit          model_live = 1'b0;
    logic        m_we;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wdata;
    logic        m_mis = 1'b0;
    logic [31:0] cur_rdata = 32'd0;

    // Perform the captured request on the byte memory and produce its result.
    task automatic model_commit();
        int size, base, off;
        logic [31:0] v;
        size = (m_f3[1:0] == 2'b00) ? 1 : (m_f3[1:0] == 2'b01) ? 2 : 4;
        base = int'(m_addr[11:2]) * 4;
        off  = (size == 1) ? int'(m_addr[1:0]) : (size == 2) ? int'(m_addr[1]) * 2 : 0;
        m_mis = MIS_EN && ((size == 2 && m_addr[0]) || (size == 4 && m_addr[1:0] != 2'b00));
        if (m_we || m_mis) begin
            if (m_we && !m_mis)
                for (int k = 0; k < size; k++) ref_mem[base + off + k] = m_wdata[8*k +: 8];
            cur_rdata = 32'd0;
        end else begin
            v = 32'd0;
            for (int k = 0; k < size; k++) v[8*k +: 8] = ref_mem[base + off + k];
            if (size == 1 && !m_f3[2] && v[7])  v = v | 32'hFFFF_FF00;
            if (size == 2 && !m_f3[2] && v[15]) v = v | 32'hFFFF_0000;
            cur_rdata = v;
        end
    endtask

    initial begin
        for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
    end

    // Compare process: outputs predicted for this cycle, then model advances
    // across the coming rising edge using the inputs that edge will sample.
    always @(negedge clk) begin
        bit idle_m, in_acc, in_done;
        idle_m  = !busy;
        in_acc  = busy && (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + LAT);
        in_done = busy && (cyc == acc_cyc + LAT + 1);
        if (model_live) begin
            check("stall", stall, (idle_m && req_valid) || in_acc);
            check("rvalid", rvalid, in_done);
            check("misalign", misalign, in_done && m_mis);
            check("rdata", rdata, cur_rdata);
        end
        if (reset) begin
            busy       = 1'b0;
            cur_rdata  = 32'd0;
            m_mis      = 1'b0;
            model_live = 1'b1;
        end else begin
            if (in_done) busy = 1'b0;
            if (in_acc && cyc == acc_cyc + LAT) model_commit();
            if (idle_m && req_valid) begin
                busy    = 1'b1;
                acc_cyc = cyc;
                m_we    = req_we;
                m_f3    = req_funct3;
                m_addr  = req_addr;
                m_wdata = req_wdata;
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    // Issue one request in an IDLE cycle, scramble inputs while stalled, and
    // check the completion against hand-computed values.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_mis, input string name);
        int n_stall, lat;
        logic got, mis;
        logic [31:0] rd;
        n_stall = 0; lat = -1; got = 1'b0; mis = 1'bx; rd = 'x;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (rvalid) begin
                got = 1'b1; lat = i; rd = rdata; mis = misalign;
                break;
            end
            @(posedge clk); #1;
            req_valid  = 1'b1;
            req_we     = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
        check({name, "_done"}, got, 1'b1);
        check({name, "_lat"}, lat, LAT + 1);
        check({name, "_stall"}, n_stall, LAT + 1);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_mis"}, mis, exp_mis);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int rv_count;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_rdata", rdata, 32'd0);
        check("reset_rvalid", rvalid, 1'b0);
        check("reset_misalign", misalign, 1'b0);
        check("reset_stall", stall, 1'b0);

        // word store/load
        do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw_10");
        do_req(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw_10");
        // byte lanes
        do_req(1, 3'b010, 32'h10, 32'h11223344, 32'h0, 0, "sw_10b");
        do_req(1, 3'b000, 32'h13, 32'hFFFFFF80, 32'h0, 0, "sb_13");
        do_req(0, 3'b010, 32'h10, 32'h0, 32'h80223344, 0, "lw_10b");
        do_req(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0, "lb_13");
        do_req(0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0, "lbu_13");
        do_req(0, 3'b000, 32'h12, 32'h0, 32'h00000022, 0, "lb_12");
        // half lanes
        do_req(1, 3'b010, 32'h20, 32'h55667788, 32'h0, 0, "sw_20");
        do_req(1, 3'b001, 32'h22, 32'h12348001, 32'h0, 0, "sh_22");
        do_req(0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 0, "lh_22");
        do_req(0, 3'b101, 32'h22, 32'h0, 32'h00008001, 0, "lhu_22");
        do_req(0, 3'b010, 32'h20, 32'h0, 32'h80017788, 0, "lw_20");
        do_req(0, 3'b001, 32'h20, 32'h0, 32'h00007788, 0, "lh_20");
        do_req(0, 3'b011, 32'h20, 32'h0, 32'h80017788, 0, "l011_20");
        do_req(0, 3'b111, 32'h20, 32'h0, 32'h80017788, 0, "l111_20");
        // address wrap
        do_req(1, 3'b010, 32'h10, 32'hA5A5A5A5, 32'h0, 0, "sw_wrap");
        do_req(0, 3'b010, 32'h1010, 32'h0, 32'hA5A5A5A5, 0, "lw_1010");
        idle(2);

        // reset during first ACCESS cycle aborts the store
        do_req(1, 3'b010, 32'h40, 32'h0, 32'h0, 0, "sw_40_zero");
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h1;
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        rv_count = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rvalid) rv_count++;
        end
        check("abort_no_rvalid", rv_count, 0);
        do_req(0, 3'b010, 32'h40, 32'h0, 32'h0, 0, "lw_40_abort");

        // reset wins over acceptance in the same cycle
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h77;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("rst_prio_stall", stall, 1'b0);
        idle(4);
        do_req(0, 3'b010, 32'h40, 32'h0, 32'h0, 0, "lw_40_prio");

        // misaligned accesses
        do_req(1, 3'b010, 32'h41, 32'hCAFEF00D, 32'h0, MIS_EN, "sw_41");
        do_req(0, 3'b010, 32'h40, 32'h0, MIS_EN ? 32'h0 : 32'hCAFEF00D, 0, "lw_40_mis");
        do_req(0, 3'b001, 32'h23, 32'h0, MIS_EN ? 32'h0 : 32'hFFFF8001, MIS_EN, "lh_23");
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
